// File: rtl/iir_coeff_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iir_coeff_sequencer: shadows word-serial coefficient writes and loads one |
// | IIR stage (numerator, then denominator) inside a sample-traffic gap.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module iir_coeff_sequencer #(
    parameter int COEFF_WIDTH     = 20,
    parameter int NUM_STAGES      = 3,
    parameter int NUM_COEFF_DEPTH = 3,
    parameter int DEN_COEFF_DEPTH = 2,
    parameter int GAP_TIMEOUT     = 255,
    localparam int STAGE_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [STAGE_W-1:0]                     cfg_stage,
    input  logic [2:0]                             cfg_idx,
    input  logic signed [COEFF_WIDTH-1:0]          cfg_data,
    input  logic                                   cfg_commit,
    input  logic                                   sample_valid,
    output logic [NUM_COEFF_DEPTH*COEFF_WIDTH-1:0] num_coeff_out,
    output logic [DEN_COEFF_DEPTH*COEFF_WIDTH-1:0] den_coeff_out,
    output logic [NUM_STAGES-1:0]                  num_coeff_wr_en,
    output logic [NUM_STAGES-1:0]                  den_coeff_wr_en,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic [1:0]                             err_code,
    input  logic                                   err_clr
);
    localparam int NUM_TAPS = NUM_COEFF_DEPTH + DEN_COEFF_DEPTH;
    localparam int CNT_W    = $clog2(GAP_TIMEOUT + 1);

    localparam logic [1:0]            ERR_ADDR       = 2'd1;
    localparam logic [1:0]            ERR_INCOMPLETE = 2'd2;
    localparam logic [1:0]            ERR_TIMEOUT    = 2'd3;
    localparam logic [NUM_STAGES-1:0] STAGE_ONE      = NUM_STAGES'(1);
    localparam logic [NUM_TAPS-1:0]   TAP_ONE        = NUM_TAPS'(1);
    localparam logic [NUM_TAPS-1:0]   ALL_TAPS       = '1;
    localparam logic [CNT_W-1:0]      GAP_LAST       = CNT_W'(GAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GAP = 3'd1,
        WR_NUM   = 3'd2,
        WR_DEN   = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state;
    logic [NUM_TAPS-1:0] mask;
    logic [STAGE_W-1:0]  stage_q;
    logic [CNT_W-1:0]    gap_cnt;

    logic                wr_fire;
    logic                bad_addr;
    logic                wr_ok;
    logic [NUM_TAPS-1:0] mask_nxt;
    logic [STAGE_W-1:0]  stage_nxt;

    // cfg_ready is only high in IDLE, so wr_fire implies the FSM is idle.
    always_comb begin
        wr_fire   = cfg_valid && cfg_ready;
        bad_addr  = (int'(cfg_idx) >= NUM_TAPS) ||
                    (int'(cfg_stage) >= NUM_STAGES) ||
                    ((mask != '0) && (cfg_stage != stage_q));
        wr_ok     = wr_fire && !bad_addr;
        mask_nxt  = wr_ok ? (mask | (TAP_ONE << cfg_idx)) : mask;
        stage_nxt = (wr_ok && (mask == '0)) ? cfg_stage : stage_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mask            <= '0;
            stage_q         <= '0;
            gap_cnt         <= '0;
            num_coeff_out   <= '0;
            den_coeff_out   <= '0;
            num_coeff_wr_en <= '0;
            den_coeff_wr_en <= '0;
            cfg_ready       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            err_code        <= 2'd0;
        end else begin
            num_coeff_wr_en <= '0;
            den_coeff_wr_en <= '0;
            done            <= 1'b0;

            // Later error assignments below override this clear.
            if (err_clr) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end

            case (state)
                IDLE: begin
                    if (wr_fire && bad_addr) begin
                        err      <= 1'b1;
                        err_code <= ERR_ADDR;
                    end
                    if (wr_ok) begin
                        for (int k = 0; k < NUM_COEFF_DEPTH; k++) begin
                            if (int'(cfg_idx) == k)
                                num_coeff_out[k*COEFF_WIDTH +: COEFF_WIDTH] <= cfg_data;
                        end
                        for (int k = 0; k < DEN_COEFF_DEPTH; k++) begin
                            if (int'(cfg_idx) == NUM_COEFF_DEPTH + k)
                                den_coeff_out[k*COEFF_WIDTH +: COEFF_WIDTH] <= cfg_data;
                        end
                    end
                    mask    <= mask_nxt;
                    stage_q <= stage_nxt;
                    if (cfg_commit) begin
                        if (mask_nxt == ALL_TAPS) begin
                            state     <= WAIT_GAP;
                            gap_cnt   <= '0;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                        end else begin
                            mask     <= '0;
                            err      <= 1'b1;
                            err_code <= ERR_INCOMPLETE;
                        end
                    end
                end

                WAIT_GAP: begin
                    if (!sample_valid) begin
                        state           <= WR_NUM;
                        num_coeff_wr_en <= STAGE_ONE << stage_q;
                    end else if (gap_cnt == GAP_LAST) begin
                        state     <= IDLE;
                        mask      <= '0;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        err       <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                // Separate cycle: the stage drops a den load coincident with a num load.
                WR_NUM: begin
                    state           <= WR_DEN;
                    den_coeff_wr_en <= STAGE_ONE << stage_q;
                end

                WR_DEN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state     <= IDLE;
                    mask      <= '0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_coeff_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iir_coeff_sequencer: randomized bench with a transaction-level model. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_iir_coeff_sequencer;
    localparam int CW = 20;
    localparam int NS = 3;
    localparam int TO_SHORT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic [1:0] cfg_stage = '0;
    logic [2:0] cfg_idx = '0;
    logic signed [CW-1:0] cfg_data = '0;
    logic cfg_commit = 1'b0;
    logic sample_valid = 1'b0;
    logic err_clr = 1'b0;

    logic cfg_ready, busy, done, err;
    logic [1:0] err_code;
    logic [3*CW-1:0] num_out;
    logic [2*CW-1:0] den_out;
    logic [NS-1:0] num_we, den_we;

    logic t_ready, t_busy, t_done, t_err_o;
    logic [1:0] t_code_o;
    logic [3*CW-1:0] t_num_out;
    logic [2*CW-1:0] t_den_out;
    logic [NS-1:0] t_num_we, t_den_we;

    always #5 clk = ~clk;

    iir_coeff_sequencer #(.COEFF_WIDTH(CW), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_stage(cfg_stage), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .sample_valid(sample_valid),
        .num_coeff_out(num_out), .den_coeff_out(den_out),
        .num_coeff_wr_en(num_we), .den_coeff_wr_en(den_we),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_clr(err_clr));

    iir_coeff_sequencer #(.COEFF_WIDTH(CW), .NUM_STAGES(NS), .GAP_TIMEOUT(TO_SHORT)) dut_t (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(t_ready),
        .cfg_stage(cfg_stage), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .sample_valid(sample_valid),
        .num_coeff_out(t_num_out), .den_coeff_out(t_den_out),
        .num_coeff_wr_en(t_num_we), .den_coeff_wr_en(t_den_we),
        .busy(t_busy), .done(t_done), .err(t_err_o), .err_code(t_code_o), .err_clr(err_clr));

    // Reference model: shadow words, written-mask, latched stage, error regs.
    logic [CW-1:0] m_coef [5];
    logic [4:0]    m_mask;
    int            m_stage;
    logic          me_err, mt_err;
    logic [1:0]    me_code, mt_code;
    int            ord [5];
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3*CW-1:0] m_num();
        return {m_coef[2], m_coef[1], m_coef[0]};
    endfunction

    function automatic logic [2*CW-1:0] m_den();
        return {m_coef[4], m_coef[3]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) m_coef[i] = '0;
        m_mask = '0; m_stage = 0;
        me_err = 1'b0; me_code = 2'd0; mt_err = 1'b0; mt_code = 2'd0;
    endfunction

    function automatic void model_write(input int s, input int idx, input logic [CW-1:0] d);
        if (idx > 4 || s >= NS || (m_mask != 0 && s != m_stage)) begin
            me_err = 1'b1; me_code = 2'd1; mt_err = 1'b1; mt_code = 2'd1;
        end else begin
            if (m_mask == 0) m_stage = s;
            m_coef[idx] = d;
            m_mask[idx] = 1'b1;
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_err"}, err, me_err);
        chk({tag, "_code"}, err_code, me_code);
        chk({tag, "_t_err"}, t_err_o, mt_err);
        chk({tag, "_t_code"}, t_code_o, mt_code);
        chk({tag, "_num"}, num_out, m_num());
        chk({tag, "_den"}, den_out, m_den());
        chk({tag, "_ready"}, cfg_ready, 1'b1);
    endtask

    task automatic wr(input int s, input int idx, input logic [CW-1:0] d, input bit clr);
        cfg_valid = 1'b1; cfg_stage = s[1:0]; cfg_idx = idx[2:0]; cfg_data = d; err_clr = clr;
        if (clr) begin
            me_err = 1'b0; me_code = 2'd0; mt_err = 1'b0; mt_code = 2'd0;
        end
        model_write(s, idx, d);
        step();
        cfg_valid = 1'b0; err_clr = 1'b0;
        check_idle("wr");
    endtask

    task automatic clr_only();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        me_err = 1'b0; me_code = 2'd0; mt_err = 1'b0; mt_code = 2'd0;
        check_idle("clr");
    endtask

    // Writes the first n taps of a fresh random order for stage s.
    task automatic write_some(input int s, input int n);
        for (int i = 0; i < 5; i++) ord[i] = i;
        for (int i = 4; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int tmp = ord[i];
            ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < n; i++) wr(s, ord[i], CW'($urandom), 1'b0);
    endtask

    // Commit in cycle 0, sample_valid high for cycles 1..gap, gap cycle gap+1.
    task automatic commit(input bit with_wr, input int s, input int idx,
                          input logic [CW-1:0] d, input int gap);
        bit full, t_to;
        int es;
        int num_at = -1, den_at = -1, done_at = -1, rdy_at = -1, nn = 0, nd = 0, ndn = 0;
        int tnum_at = -1, tn = 0, tnd = 0, tdn = 0, trdy_at = -1;
        logic [NS-1:0] numv = '0, denv = '0;
        logic busy1 = 1'b0;
        bit stable = 1'b1;
        logic [63:0] oh;
        cfg_commit = 1'b1; cfg_valid = with_wr; cfg_stage = s[1:0]; cfg_idx = idx[2:0];
        cfg_data = d; sample_valid = 1'($urandom_range(0, 1));
        if (with_wr) model_write(s, idx, d);
        full = (m_mask == 5'h1f);
        es = m_stage;
        step();
        cfg_commit = 1'b0; cfg_valid = 1'b0;
        if (!full) begin
            me_err = 1'b1; me_code = 2'd2; mt_err = 1'b1; mt_code = 2'd2;
        end
        t_to = full && (gap >= TO_SHORT);
        if (t_to) begin mt_err = 1'b1; mt_code = 2'd3; end
        m_mask = '0;
        for (int c = 1; c <= gap + 8; c++) begin
            if (c == 1) busy1 = busy;
            if (num_we != '0) begin nn++; if (num_at < 0) begin num_at = c; numv = num_we; end end
            if (den_we != '0) begin nd++; if (den_at < 0) begin den_at = c; denv = den_we; end end
            if (done) begin ndn++; if (done_at < 0) done_at = c; end
            if (cfg_ready && rdy_at < 0) rdy_at = c;
            if (t_num_we != '0) begin tn++; if (tnum_at < 0) tnum_at = c; end
            if (t_den_we != '0) tnd++;
            if (t_done) tdn++;
            if (t_ready && trdy_at < 0) trdy_at = c;
            if (num_out !== m_num() || den_out !== m_den()) stable = 1'b0;
            sample_valid = (c <= gap);
            step();
        end
        sample_valid = 1'b0;
        oh = 64'(1) << es;
        chk("cm_stable", stable, 1'b1);
        chk("cm_busy1", busy1, full);
        chk("cm_num_cnt", nn, full ? 1 : 0);
        chk("cm_den_cnt", nd, full ? 1 : 0);
        chk("cm_done_cnt", ndn, full ? 1 : 0);
        chk("cm_ready_at", rdy_at, full ? gap + 5 : 1);
        if (full) begin
            chk("cm_num_at", num_at, gap + 2);
            chk("cm_num_oh", numv, oh);
            chk("cm_den_at", den_at, gap + 3);
            chk("cm_den_oh", denv, oh);
            chk("cm_done_at", done_at, gap + 4);
        end
        chk("cmt_num_cnt", tn, (full && !t_to) ? 1 : 0);
        chk("cmt_den_cnt", tnd, (full && !t_to) ? 1 : 0);
        chk("cmt_done_cnt", tdn, (full && !t_to) ? 1 : 0);
        chk("cmt_ready_at", trdy_at, !full ? 1 : (t_to ? TO_SHORT + 1 : gap + 5));
        if (full && !t_to) chk("cmt_num_at", tnum_at, gap + 2);
        check_idle("cm");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, cfg_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, {err, err_code}, 3'b000);
        chk({tag, "_we"}, {num_we, den_we}, '0);
        chk({tag, "_bus"}, {num_out, den_out}, '0);
        chk({tag, "_t_ready"}, t_ready, 1'b1);
        chk({tag, "_t_we"}, {t_num_we, t_den_we}, '0);
    endtask

    task automatic rst_mid(input bit in_wr_num);
        int s = $urandom_range(0, NS - 1);
        int pulses = 0;
        write_some(s, 5);
        cfg_commit = 1'b1; sample_valid = 1'b0;
        step();
        cfg_commit = 1'b0;
        if (!in_wr_num) begin
            sample_valid = 1'b1;
            step(); step();
            chk("rm_busy_pre", busy, 1'b1);
        end else begin
            step();
            chk("rm_num_pre", num_we, 64'(1) << s);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rm");
        sample_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) rst_n = 1'b1;
            if ({num_we, den_we, t_num_we, t_den_we, done} != '0) pulses++;
            step();
        end
        chk("rm_no_load", pulses, 0);
        check_reset_outputs("rm_post");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] pv [5];
        pv[0] = 20'h37061; pv[1] = 20'h5907c; pv[2] = 20'h37061;
        pv[3] = 20'h5907c; pv[4] = 20'h2e0c3;
        model_reset();
        step(); step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        check_reset_outputs("rst_rel");

        // Directed: stage 1 notch coefficients, immediate gap then a 10-cycle burst.
        for (int i = 0; i < 5; i++) wr(1, i, pv[i], 1'b0);
        commit(1'b0, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) wr(1, i, pv[i], 1'b0);
        commit(1'b0, 0, 0, '0, 10);

        // Incomplete commit, then a full one.
        for (int i = 0; i < 4; i++) wr(2, i, CW'($urandom), 1'b0);
        commit(1'b0, 0, 0, '0, 0);
        write_some(0, 5);
        commit(1'b0, 0, 0, '0, 1);

        // Address rejections: idx 5, stage 3, stage mismatch.
        wr(0, 0, CW'($urandom), 1'b0);
        wr(0, 5, CW'($urandom), 1'b0);
        wr(3, 1, CW'($urandom), 1'b0);
        wr(1, 1, CW'($urandom), 1'b0);
        wr(0, 1, CW'($urandom), 1'b1);
        wr(2, 2, CW'($urandom), 1'b1);
        wr(0, 2, CW'($urandom), 1'b0);
        wr(0, 3, CW'($urandom), 1'b0);
        commit(1'b1, 0, 4, CW'($urandom), 2);
        clr_only();

        // Gap timeout on the short-timeout instance.
        write_some(2, 5);
        commit(1'b0, 0, 0, '0, 6);
        clr_only();

        for (int it = 0; it < 30; it++) begin
            int s = $urandom_range(0, NS - 1);
            int nw = $urandom_range(3, 5);
            bit ww;
            write_some(s, nw);
            if ($urandom_range(0, 3) == 0)
                wr($urandom_range(0, 3), $urandom_range(0, 7), CW'($urandom), 1'($urandom_range(0, 1)));
            ww = (nw < 5) && ($urandom_range(0, 1) == 1);
            commit(ww, s, ww ? ord[nw] : 0, CW'($urandom), $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) clr_only();
        end

        rst_mid(1'b0);
        rst_mid(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
